// File: rtl/toggle_fsm_arbiter_if.sv
// rtl/toggle_fsm_arbiter_if.sv - requester-side bundle of the toggle FSM arbiter
interface toggle_fsm_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_level;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic            err;
   logic            busy;

   modport master (
      output req, req_level,
      input  gnt, done, err, busy
   );

   modport slave (
      input  req, req_level,
      output gnt, done, err, busy
   );
endinterface

// File: rtl/toggle_fsm_arbiter.sv
// rtl/toggle_fsm_arbiter.sv - round-robin sequencer driving a shared toggle FSM; TOGGLE_ARB_TIMEOUT_EN adds a WAIT timeout
module toggle_fsm_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   toggle_fsm_arbiter_if.slave  bus,
   output logic                 fsm_din,
   input  logic                 fsm_dout
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, CHECK, PULSE, WAIT, DONE} state_t;

   state_t          state, state_nx;
   logic [NREQ-1:0] gnt_q;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gidx;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            level_q;
   logic            match;

   assign match = (fsm_dout == level_q);

`ifdef TOGGLE_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          err_q;
   logic          expire;

   assign expire = (cnt == CW'(TIMEOUT - 1));
`endif

   // First set request at or above ptr, wrapping around.
   always_comb begin
      int idx;
      idx      = 0;
      pick_any = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!pick_any && bus.req[idx]) begin
            pick_any = 1'b1;
            pick_idx = PW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (pick_any) state_nx = CHECK;
         CHECK: state_nx = match ? DONE : PULSE;
         PULSE: state_nx = WAIT;
         WAIT: begin
            if (match) state_nx = DONE;
`ifdef TOGGLE_ARB_TIMEOUT_EN
            else if (expire) state_nx = DONE;
`endif
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q   <= '0;
         ptr     <= '0;
         gidx    <= '0;
         level_q <= 1'b0;
`ifdef TOGGLE_ARB_TIMEOUT_EN
         cnt     <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_q           <= '0;
                  gnt_q[pick_idx] <= 1'b1;
                  gidx            <= pick_idx;
                  level_q         <= bus.req_level[pick_idx];
               end
`ifdef TOGGLE_ARB_TIMEOUT_EN
               err_q <= 1'b0;
`endif
            end
`ifdef TOGGLE_ARB_TIMEOUT_EN
            PULSE: cnt <= '0;
            WAIT: begin
               if (!match) begin
                  if (expire) err_q <= 1'b1;
                  else        cnt   <= cnt + CW'(1);
               end
            end
`endif
            DONE: begin
               gnt_q <= '0;
               ptr   <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
`ifdef TOGGLE_ARB_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from registered state so reset clears them immediately.
   always_comb begin
      bus.gnt  = gnt_q;
      bus.done = (state == DONE) ? gnt_q : '0;
      bus.busy = (state != IDLE);
      fsm_din  = (state == PULSE);
`ifdef TOGGLE_ARB_TIMEOUT_EN
      bus.err  = (state == DONE) && err_q;
`else
      bus.err  = 1'b0;
`endif
   end
endmodule
